ajuste_ctrl: RTL and testbench
==============================

Name: ajuste_ctrl

Overview:
- Time-of-day controller with adjust mode for the VGA clock display.
- Keeps hours/minutes/seconds from a 1 Hz tick. Sequences a set-mode FSM driven by debounced buttons.
- Drives the enable and restart of the blink-divider counter. Returns per-field display gates so the selected field flashes while it is being adjusted.

Parameters:
- HOUR_MAX, 23, last hour value before wrap to 0
- MIN_MAX, 59, last minute/second value before wrap to 0

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-cycle pulse, once per second
- btn_mode  in  1  debounced, synchronized level; each press cycles the adjust field
- btn_up  in  1  debounced level; each press increments the selected field
- btn_down  in  1  debounced level; each press decrements the selected field
- blink  in  1  toggling flag from the blink divider (the divider's f output)
- blink_en  out  1  enable for the blink divider
- blink_rst  out  1  active-high synchronous restart for the blink divider
- hours  out  5  current hours, 0..HOUR_MAX
- minutes  out  6  current minutes, 0..MIN_MAX
- seconds  out  6  current seconds, 0..MIN_MAX
- adj_field  out  2  0=none (RUN), 1=hours, 2=minutes, 3=seconds
- show_h  out  1  display gate for hours
- show_m  out  1  display gate for minutes
- show_s  out  1  display gate for seconds

Behaviour:
- Reset (reset=0, async):
  - hours=minutes=seconds=0, state=RUN, blink_rst=0.
  - Button history registers are set to 1. A button held through reset release produces no press until it is released and pressed again.
- Press detect: press_x = btn_x & ~btn_x_q, where btn_x_q is btn_x registered each clk. Exactly one press per 0->1 transition.
- FSM states: RUN -> SET_H -> SET_M -> SET_S -> RUN. Advances one step per mode press, on the clock edge where the press is detected.
- adj_field encodes the state (RUN=0, SET_H=1, SET_M=2, SET_S=3). It is registered and changes on the same edge as the state.
- RUN:
  - On sec_tick, seconds += 1.
  - seconds MIN_MAX -> 0 with carry to minutes; minutes MIN_MAX -> 0 with carry to hours; hours HOUR_MAX -> 0.
  - up/down presses are ignored.
- SET_x:
  - sec_tick is ignored; the clock is halted.
  - An up press increments the selected field, wrapping MAX -> 0, with no carry into any other field.
  - A down press decrements the selected field, wrapping 0 -> MAX, with no borrow.
  - The update occurs on the same edge the press is detected (single-cycle latency from the sampled input).
- Simultaneous events:
  - up and down in the same cycle: no change.
  - mode together with up/down: mode wins and the field is not changed.
  - Leaving SET_S to RUN while sec_tick is high in the same cycle: that tick is ignored. Counting resumes on the next tick.
- blink_en = 1 in all SET states, 0 in RUN (combinational from state).
- blink_rst:
  - Registered, one-cycle high pulse on the cycle after any state change or any accepted up/down press.
  - This restarts the blink phase with f=0, so the field is visible immediately after an edit.
  - blink_rst = 0 otherwise.
- Display gates: show_h = ~(state==SET_H & blink); show_m and show_s follow the same pattern for SET_M and SET_S. All gates = 1 in RUN.
- Field values always remain within range. No out-of-range value is reachable, including at reset or mid-operation.
- An asynchronous reset asserted mid-adjust returns to RUN at 00:00:00 immediately, with no clock edge required.

Test Plan:
1. Start at 23:59:58 in RUN; apply 2 sec_ticks -> 23:59:59, then 00:00:00. adj_field=0, blink_en=0.
2. Mode press x1 -> adj_field=1, blink_en=1, blink_rst high for exactly 1 cycle. Then drive blink=1 -> show_h=0 while show_m=1 and show_s=1.
3. In SET_H with hours=23: up press -> hours=0. Then down press -> hours=23. minutes and seconds unchanged. sec_tick pulses during SET_H leave seconds unchanged.
4. In SET_M with minutes=0: up and down asserted in the same cycle -> minutes stays 0. Then mode+up asserted in the same cycle -> adj_field=3 and minutes stays 0.
5. Hold btn_up high for 100 cycles in SET_S -> seconds increments by exactly 1. Hold btn_mode high through reset release -> no state change until it is released and pressed again.
6. Assert reset low mid-cycle while in SET_M with time 12:34:56 -> outputs go 00:00:00, adj_field=0, blink_en=0 immediately, with no clock edge.

Source files
------------

// File: rtl/ajuste_ctrl.sv
// Time-of-day keeper with a button-driven adjust mode.
// Drives the blink divider and per-field display gates for the VGA clock.
module ajuste_ctrl #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       blink,
  output logic       blink_en,
  output logic       blink_rst,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] adj_field,
  output logic       show_h,
  output logic       show_m,
  output logic       show_s
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam logic [5:0] HMAX = 6'(HOUR_MAX);
  localparam logic [5:0] MMAX = 6'(MIN_MAX);

  state_e     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       mode_q, up_q, down_q;
  logic       blink_rst_q, blink_rst_d;
  logic       press_mode, press_up, press_down;
  logic       edit;

  // >= / > guards keep every field in range even from a bad value
  function automatic logic [5:0] inc_w(
    input logic [5:0] v,
    input logic [5:0] mx
  );
    return (v >= mx) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_w(
    input logic [5:0] v,
    input logic [5:0] mx
  );
    return (v == 6'd0 || v > mx) ? mx : v - 6'd1;
  endfunction

  assign press_mode = btn_mode & ~mode_q;
  assign press_up   = btn_up & ~up_q;
  assign press_down = btn_down & ~down_q;
  assign edit = (state_q != RUN) & ~press_mode
              & (press_up ^ press_down);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b1;
      up_q   <= 1'b1;
      down_q <= 1'b1;
    end else begin
      mode_q <= btn_mode;
      up_q   <= btn_up;
      down_q <= btn_down;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      hours_q     <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      blink_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      blink_rst_q <= blink_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hours_d     = hours_q;
    min_d       = min_q;
    sec_d       = sec_q;
    blink_rst_d = 1'b0;
    if (press_mode) begin
      unique case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
      blink_rst_d = 1'b1;
    end
    if (state_q == RUN) begin
      if (sec_tick) begin
        sec_d = inc_w(sec_q, MMAX);
        if (sec_q >= MMAX) begin
          min_d = inc_w(min_q, MMAX);
          if (min_q >= MMAX)
            hours_d = 5'(inc_w({1'b0, hours_q}, HMAX));
        end
      end
    end else if (edit) begin
      blink_rst_d = 1'b1;
      unique case (state_q)
        SET_H: hours_d = press_up
          ? 5'(inc_w({1'b0, hours_q}, HMAX))
          : 5'(dec_w({1'b0, hours_q}, HMAX));
        SET_M: min_d = press_up
          ? inc_w(min_q, MMAX) : dec_w(min_q, MMAX);
        default: sec_d = press_up
          ? inc_w(sec_q, MMAX) : dec_w(sec_q, MMAX);
      endcase
    end
  end

  assign hours     = hours_q;
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign adj_field = state_q;
  assign blink_en  = (state_q != RUN);
  assign blink_rst = blink_rst_q;
  assign show_h    = ~((state_q == SET_H) & blink);
  assign show_m    = ~((state_q == SET_M) & blink);
  assign show_s    = ~((state_q == SET_S) & blink);

endmodule

// File: tb/tb_ajuste_ctrl.sv
// Bench for ajuste_ctrl: directed scenarios plus random
// stimulus against a wall-clock style reference model.
module tb_ajuste_ctrl;

  localparam int HM = 23;
  localparam int MM = 59;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       blink = 1'b0;
  logic       blink_en, blink_rst;
  logic       show_h, show_m, show_s;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] adj_field;

  int n_chk = 0;
  int n_fail = 0;

  int mh, mm, ms, mf;
  bit mrst;
  bit pmo, pup, pdn;

  wire [23:0] obs = {hours, minutes, seconds, adj_field,
                     blink_en, blink_rst, show_h, show_m, show_s};

  always #5 clk = ~clk;

  ajuste_ctrl #(.HOUR_MAX(HM), .MIN_MAX(MM)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .blink(blink), .blink_en(blink_en), .blink_rst(blink_rst),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .adj_field(adj_field), .show_h(show_h), .show_m(show_m),
    .show_s(show_s)
  );

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mf = 0; mrst = 0;
    pmo = 1; pup = 1; pdn = 1;
  endtask

  // Model: RUN time as seconds-of-day, SET edits as modular steps
  task automatic model_edge();
    bit pm, pu, pd;
    int t, d;
    pm = btn_mode && !pmo;
    pu = btn_up && !pup;
    pd = btn_down && !pdn;
    mrst = 0;
    if (mf == 0 && sec_tick) begin
      t = (mh * 3600 + mm * 60 + ms + 1) % ((HM + 1) * 3600);
      mh = t / 3600;
      mm = (t / 60) % 60;
      ms = t % 60;
    end
    if (pm) begin
      mf = (mf + 1) % 4;
      mrst = 1;
    end else if (mf != 0 && pu != pd) begin
      d = pu ? 1 : -1;
      if (mf == 1) mh = (mh + d + HM + 1) % (HM + 1);
      if (mf == 2) mm = (mm + d + MM + 1) % (MM + 1);
      if (mf == 3) ms = (ms + d + MM + 1) % (MM + 1);
      mrst = 1;
    end
    pmo = btn_mode; pup = btn_up; pdn = btn_down;
  endtask

  function automatic logic [23:0] expv();
    return {5'(mh), 6'(mm), 6'(ms), 2'(mf),
            logic'(mf != 0), logic'(mrst),
            logic'(!(mf == 1 && blink)),
            logic'(!(mf == 2 && blink)),
            logic'(!(mf == 3 && blink))};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input bit mo, input bit up, input bit dn);
    btn_mode = mo; btn_up = up; btn_down = dn;
    cyc();
    btn_mode = 0; btn_up = 0; btn_down = 0;
    cyc();
  endtask

  task automatic do_reset(input bit hold_mode);
    @(negedge clk);
    btn_mode = hold_mode; btn_up = 0; btn_down = 0;
    sec_tick = 0; blink = 0;
    reset = 0;
    #1 model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset(0);
    n_chk++;
    if (obs !== 24'h000007) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 24'h000007);
    end
    cyc();
    n_chk++;
    if (obs !== expv()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_rollover();
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
    press(1, 0, 0);
    n_chk++;
    if ({hours, minutes, seconds, adj_field} !== {5'd23, 6'd59, 6'd58, 2'd0}) begin
      n_fail++;
      $display("FAIL load_235958: got %0d:%0d:%0d f%0d expected 23:59:58 f0",
               hours, minutes, seconds, adj_field);
    end
    sec_tick = 1; cyc(); sec_tick = 0;
    n_chk++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59} || obs !== expv()) begin
      n_fail++;
      $display("FAIL tick_235959: got %h expected %h", obs, expv());
    end
    sec_tick = 1; cyc(); sec_tick = 0;
    n_chk++;
    if ({hours, minutes, seconds, adj_field, blink_en} !== 20'd0) begin
      n_fail++;
      $display("FAIL wrap_000000: got %0d:%0d:%0d f%0d en%0b expected 0:0:0 f0 en0",
               hours, minutes, seconds, adj_field, blink_en);
    end
  endtask

  task automatic test_mode_blink();
    btn_mode = 1; cyc();
    n_chk++;
    if ({adj_field, blink_en, blink_rst} !== 4'b0111) begin
      n_fail++;
      $display("FAIL mode_enter: got f%0d en%0b rst%0b expected f1 en1 rst1",
               adj_field, blink_en, blink_rst);
    end
    btn_mode = 0; cyc();
    n_chk++;
    if (blink_rst !== 1'b0 || adj_field !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_pulse: got rst%0b f%0d expected rst0 f1",
               blink_rst, adj_field);
    end
    blink = 1; #1;
    n_chk++;
    if ({show_h, show_m, show_s} !== 3'b011) begin
      n_fail++;
      $display("FAIL show_gate: got %b expected 011", {show_h, show_m, show_s});
    end
    blink = 0;
  endtask

  task automatic test_set_hours();
    press(0, 0, 1);
    n_chk++;
    if (hours !== 5'd23) begin
      n_fail++;
      $display("FAIL h_dec_wrap0: got %0d expected 23", hours);
    end
    press(0, 1, 0);
    n_chk++;
    if (hours !== 5'd0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL h_inc_wrap: got %h expected %h", obs, expv());
    end
    press(0, 0, 1);
    n_chk++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL h_dec_wrap: got %0d:%0d:%0d expected 23:0:0",
               hours, minutes, seconds);
    end
    for (int i = 0; i < 3; i++) begin
      sec_tick = 1; cyc(); sec_tick = 0; cyc();
    end
    n_chk++;
    if (seconds !== 6'd0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL set_halts: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_simultaneous();
    press(1, 0, 0);
    btn_up = 1; btn_down = 1; cyc();
    n_chk++;
    if (minutes !== 6'd0 || blink_rst !== 1'b0 || adj_field !== 2'd2) begin
      n_fail++;
      $display("FAIL up_and_down: got m%0d rst%0b f%0d expected m0 rst0 f2",
               minutes, blink_rst, adj_field);
    end
    btn_up = 0; btn_down = 0; cyc();
    press(1, 1, 0);
    n_chk++;
    if (adj_field !== 2'd3 || minutes !== 6'd0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL mode_wins: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_hold();
    btn_up = 1;
    repeat (100) cyc();
    btn_up = 0; cyc();
    n_chk++;
    if (seconds !== 6'd1 || obs !== expv()) begin
      n_fail++;
      $display("FAIL hold_up_once: got s%0d expected s1", seconds);
    end
    do_reset(1);
    repeat (5) cyc();
    n_chk++;
    if (adj_field !== 2'd0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL held_through_reset: got f%0d expected f0", adj_field);
    end
    btn_mode = 0; cyc();
    press(1, 0, 0);
    n_chk++;
    if (adj_field !== 2'd1) begin
      n_fail++;
      $display("FAIL repress_after_reset: got f%0d expected f1", adj_field);
    end
  endtask

  task automatic test_async_reset();
    do_reset(0);
    cyc();
    press(1, 0, 0);
    for (int i = 0; i < 12; i++) press(0, 1, 0);
    press(1, 0, 0);
    for (int i = 0; i < 34; i++) press(0, 1, 0);
    press(1, 0, 0);
    for (int i = 0; i < 56; i++) press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    n_chk++;
    if ({hours, minutes, seconds, adj_field} !== {5'd12, 6'd34, 6'd56, 2'd2}) begin
      n_fail++;
      $display("FAIL load_123456: got %0d:%0d:%0d f%0d expected 12:34:56 f2",
               hours, minutes, seconds, adj_field);
    end
    #2 reset = 0;
    #1;
    n_chk++;
    if (obs !== 24'h000007) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs, 24'h000007);
    end
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(2) == 0) btn_up = ~btn_up;
      if ($urandom_range(2) == 0) btn_down = ~btn_down;
      sec_tick = ($urandom_range(2) == 0);
      blink = 1'($urandom_range(1));
      cyc();
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, expv());
      end
    end
    btn_mode = 0; btn_up = 0; btn_down = 0;
    sec_tick = 0; blink = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rollover();
    test_mode_blink();
    test_set_hours();
    test_simultaneous();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
